truth_table_sequencer: RTL and testbench
========================================

Name: truth_table_sequencer

Overview:
- Controller that exhaustively sequences a combinational function pair: a behavioural reference and a gate-only implementation (e.g. NOR-only realisation of x | ~y).
- Drives every input combination in ascending order to both implementations, waits for settling, compares outputs and accumulates an error record.
- Sits between a simple start/done host and the two implementations under check.
- Replaces hand-written stimulus lists with a reusable, self-checking sequencer.

Parameters:
- N_IN, 2: number of function inputs; vector space 0..2^N_IN-1.
- SETTLE_CYC, 1: cycles a vector is held before sampling; must be >= 1.
- CNT_W, 8: width of the mismatch counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  begin a run; sampled only in IDLE.
- abort  input  1  cancel a run in progress.
- ref_s  input  1  output of the reference implementation.
- dut_s  input  1  output of the gate-level implementation.
- vec  output  N_IN  stimulus to both implementations; for N_IN=2, vec[1]=x and vec[0]=y.
- busy  output  1  high while a run is in progress.
- done  output  1  one-cycle pulse when a run completes normally.
- pass  output  1  high when the last completed run had zero mismatches.
- err_cnt  output  CNT_W  saturating mismatch count.
- first_err_vec  output  N_IN  vector of the first mismatch in the run.
- first_err_valid  output  1  first_err_vec holds a valid value.

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE, vec=0, busy=0, done=0, pass=0, err_cnt=0, first_err_vec=0, first_err_valid=0. Reset overrides everything, including mid-run.
- States: IDLE, SETTLE, CHECK, DONE. All outputs are registered.
- IDLE, start=1 and abort=0: next cycle enters SETTLE with vec=0, busy=1, err_cnt=0, first_err_valid=0, first_err_vec=0, pass=0.
- SETTLE: hold vec for exactly SETTLE_CYC cycles, then enter CHECK.
- CHECK: one cycle. Mismatch = (ref_s !== dut_s); X or Z on either input counts as a mismatch.
  - On mismatch: err_cnt increments, saturating at 2^CNT_W-1.
  - If first_err_valid=0: latch first_err_vec=vec and set first_err_valid=1.
  - If vec < 2^N_IN-1: vec increments and the next state is SETTLE.
  - Otherwise the next state is DONE.
- Timing: each vector occupies SETTLE_CYC+1 cycles. For start sampled at edge t, DONE is entered at t + 2^N_IN*(SETTLE_CYC+1) + 1.
- DONE: one cycle. done=1, busy=0, and pass is set to (err_cnt==0) using the count including the final CHECK. Next state is IDLE.
- After DONE: vec holds its last value (2^N_IN-1). err_cnt, first_err_*, and pass hold until the next start or reset.
- start outside IDLE: ignored. start held high continuously re-launches a run on each IDLE cycle, i.e. the cycle after DONE.
- abort=1 in SETTLE, CHECK or DONE: next state is IDLE, busy=0, done=0, pass=0. err_cnt and first_err_* keep their partial values; vec holds.
- abort in IDLE has no effect. abort and start together in IDLE: abort wins and the block stays IDLE.
- No combinational path from ref_s or dut_s to any output.

Test Plan:
1. Reset: rst_n=0 for 2 cycles with start=1 -> all outputs at their reset values, state IDLE, no run started.
2. Matching implementations, both computing x|~y (N_IN=2, SETTLE_CYC=1). start pulse sampled at edge 0 -> vec = 0,0,1,1,2,2,3,3 over cycles 1-8; busy=1 in cycles 1-8; done=1 only in cycle 9; pass=1; err_cnt=0; first_err_valid=0.
3. Gate-level output stuck at 0 (reference x|~y is 1 for vec 0, 2, 3) -> err_cnt=3, first_err_vec=0, first_err_valid=1, pass=0, done in cycle 9.
4. Gate-level output stuck at 1 -> single mismatch at vec=1 -> err_cnt=1, first_err_vec=1, pass=0. Repeat with CNT_W=1 and stuck at 0 -> err_cnt saturates at 1.
5. abort=1 at cycle 4, vec=1 in CHECK -> busy=0 from cycle 5, done never pulses, pass=0. A new start afterwards -> counters cleared and the full 8-cycle run is repeated.
6. Interference during a run:
   - start pulses during busy -> ignored, timing unchanged.
   - rst_n=0 at cycle 3 -> reset values at the next edge, no done.
   - SETTLE_CYC=3 -> each vector held 4 cycles, done in cycle 17.

Source files
------------

// File: rtl/truth_table_sequencer.sv
// Exhaustive checker: walks every input vector through a reference and a gate-level
// implementation, compares their outputs and keeps a mismatch record for the host.
module truth_table_sequencer #(
  parameter int N_IN       = 2,
  parameter int SETTLE_CYC = 1,
  parameter int CNT_W      = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_ref_s,
  input  logic              i_dut_s,
  output logic [N_IN-1:0]   o_vec,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic [CNT_W-1:0]  o_err_cnt,
  output logic [N_IN-1:0]   o_first_err_vec,
  output logic              o_first_err_valid
);

  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [SW-1:0]    SET_ONE     = SW'(1);
  localparam logic [N_IN-1:0]  VEC_ONE     = N_IN'(1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  state_t            r_state;
  logic [SW-1:0]     r_settle;
  logic [N_IN-1:0]   r_vec;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic [CNT_W-1:0]  r_err_cnt;
  logic [N_IN-1:0]   r_first_err_vec;
  logic              r_first_err_valid;

  logic              w_mismatch;
  logic              w_last_vec;
  logic [CNT_W-1:0]  w_cnt_next;

  // Case inequality so an X or Z from either implementation is reported as a mismatch.
  assign w_mismatch = (i_ref_s !== i_dut_s);
  assign w_last_vec = (r_vec == {N_IN{1'b1}});
  assign w_cnt_next = (w_mismatch && !(&r_err_cnt)) ? (r_err_cnt + CNT_ONE) : r_err_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state           <= IDLE;
      r_settle          <= '0;
      r_vec             <= '0;
      r_busy            <= 1'b0;
      r_done            <= 1'b0;
      r_pass            <= 1'b0;
      r_err_cnt         <= '0;
      r_first_err_vec   <= '0;
      r_first_err_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start && !i_abort) begin
            r_state           <= SETTLE;
            r_settle          <= '0;
            r_vec             <= '0;
            r_busy            <= 1'b1;
            r_pass            <= 1'b0;
            r_err_cnt         <= '0;
            r_first_err_vec   <= '0;
            r_first_err_valid <= 1'b0;
          end
        end
        SETTLE: begin
          if (i_abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
          end else if (r_settle == SETTLE_LAST) begin
            r_state <= CHECK;
          end else begin
            r_settle <= r_settle + SET_ONE;
          end
        end
        CHECK: begin
          // An abort landing on a compare cycle discards that compare.
          if (i_abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
          end else begin
            r_err_cnt <= w_cnt_next;
            if (w_mismatch && !r_first_err_valid) begin
              r_first_err_vec   <= r_vec;
              r_first_err_valid <= 1'b1;
            end
            if (!w_last_vec) begin
              r_vec    <= r_vec + VEC_ONE;
              r_settle <= '0;
              r_state  <= SETTLE;
            end else begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_cnt_next == '0);
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          if (i_abort) begin
            r_pass <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_vec             = r_vec;
  assign o_busy            = r_busy;
  assign o_done            = r_done;
  assign o_pass            = r_pass;
  assign o_err_cnt         = r_err_cnt;
  assign o_first_err_vec   = r_first_err_vec;
  assign o_first_err_valid = r_first_err_valid;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Scoreboard bench: the stimulus side predicts each run's outcome from the truth table and
// queues it; an independent monitor pops and compares whenever the sequencer pulses done.
module tb_truth_table_sequencer;

  localparam int N      = 2;
  localparam int S      = 1;
  localparam int W      = 8;
  localparam int NV     = 1 << N;
  localparam int RUNLEN = NV * (S + 1);

  localparam int SB_S      = 3;
  localparam int SB_RUNLEN = NV * (SB_S + 1);

  logic         clk = 1'b0;
  logic         rstN, start, abortIn, refS, dutS;
  logic [N-1:0] vec, firstVec;
  logic         busy, done, pass, firstValid;
  logic [W-1:0] errCnt;

  logic         startB, refSB, dutSB;
  logic [N-1:0] vecB, firstVecB;
  logic         busyB, doneB, passB, firstValidB;
  logic [0:0]   errCntB;

  int           faultMode;
  logic [NV-1:0] faultMask;
  logic         wNy, wT, gateS;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int doneCyc;
    int errs;
    int firstV;
    int firstOk;
    int passExp;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  truth_table_sequencer #(.N_IN(N), .SETTLE_CYC(S), .CNT_W(W)) dut (
    .i_clk(clk), .i_rst_n(rstN), .i_start(start), .i_abort(abortIn),
    .i_ref_s(refS), .i_dut_s(dutS), .o_vec(vec), .o_busy(busy), .o_done(done),
    .o_pass(pass), .o_err_cnt(errCnt), .o_first_err_vec(firstVec),
    .o_first_err_valid(firstValid)
  );

  truth_table_sequencer #(.N_IN(N), .SETTLE_CYC(SB_S), .CNT_W(1)) dutB (
    .i_clk(clk), .i_rst_n(rstN), .i_start(startB), .i_abort(1'b0),
    .i_ref_s(refSB), .i_dut_s(dutSB), .o_vec(vecB), .o_busy(busyB), .o_done(doneB),
    .o_pass(passB), .o_err_cnt(errCntB), .o_first_err_vec(firstVecB),
    .o_first_err_valid(firstValidB)
  );

  // Behavioural x|~y against a NOR-only realisation with injectable faults.
  assign refS  = vec[1] | ~vec[0];
  assign wNy   = ~(vec[0] | vec[0]);
  assign wT    = ~(vec[1] | wNy);
  assign gateS = ~(wT | wT);
  assign dutS  = (faultMode == 1) ? 1'b0 :
                 (faultMode == 2) ? 1'b1 : (gateS ^ faultMask[vec]);

  assign refSB = vecB[1] | ~vecB[0];
  assign dutSB = 1'b0;

  function automatic int refFunc(input int v);
    int x, y;
    x = (v >> 1) & 1;
    y = v & 1;
    return (x == 1 || y == 0) ? 1 : 0;
  endfunction

  function automatic int isMis(input int mode, input logic [NV-1:0] mask, input int v);
    if (mode == 1) return (refFunc(v) != 0) ? 1 : 0;
    if (mode == 2) return (refFunc(v) != 1) ? 1 : 0;
    return mask[v] ? 1 : 0;
  endfunction

  task automatic checkOutput(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued prediction.
  always @(negedge clk) begin
    exp_t e;
    if (rstN && done) begin
      if (sbq.size() == 0) begin
        checkOutput("unexpected_done", 1, 0);
      end else begin
        e = sbq.pop_front();
        checkOutput("done_cycle", cyc, e.doneCyc);
        checkOutput("err_cnt", int'(errCnt), e.errs);
        checkOutput("first_err_vec", int'(firstVec), e.firstV);
        checkOutput("first_err_valid", int'(firstValid), e.firstOk);
        checkOutput("pass", int'(pass), e.passExp);
        checkOutput("busy_at_done", int'(busy), 0);
        checkOutput("vec_at_done", int'(vec), NV - 1);
      end
    end
  end

  // killType: 0 none, 1 abort at run-cycle killK, 2 reset at run-cycle killK.
  task automatic applyStimulus(input int mode, input logic [NV-1:0] mask, input int killK,
                               input int killType, input bit noise);
    int errs, first, t, pErrs, pFirst;
    errs  = 0;
    first = -1;
    faultMode = mode;
    faultMask = mask;
    for (int v = 0; v < NV; v++) begin
      if (isMis(mode, mask, v) == 1) begin
        errs++;
        if (first < 0) first = v;
      end
    end
    @(negedge clk);
    start = 1'b1;
    t = cyc + 1;
    if (killType == 0)
      sbq.push_back('{t + RUNLEN, errs, (first < 0) ? 0 : first, (first < 0) ? 0 : 1,
                      (errs == 0) ? 1 : 0});
    for (int k = 1; k <= RUNLEN + 1; k++) begin
      @(negedge clk);
      start = (noise && k <= RUNLEN - 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (k <= RUNLEN) begin
        checkOutput("vec_trace", int'(vec), (k - 1) / (S + 1));
        checkOutput("busy_trace", int'(busy), 1);
      end
      if (killType != 0 && k == killK) begin
        if (killType == 1) abortIn = 1'b1;
        else rstN = 1'b0;
        @(negedge clk);
        abortIn = 1'b0;
        rstN    = 1'b1;
        start   = 1'b0;
        pErrs  = 0;
        pFirst = -1;
        for (int v = 0; v < NV; v++) begin
          if (v * (S + 1) + S + 1 < k && isMis(mode, mask, v) == 1) begin
            pErrs++;
            if (pFirst < 0) pFirst = v;
          end
        end
        checkOutput("kill_busy", int'(busy), 0);
        checkOutput("kill_done", int'(done), 0);
        checkOutput("kill_pass", int'(pass), 0);
        if (killType == 1) begin
          checkOutput("abort_vec", int'(vec), (k - 1) / (S + 1));
          checkOutput("abort_err_cnt", int'(errCnt), pErrs);
          checkOutput("abort_first_valid", int'(firstValid), (pFirst < 0) ? 0 : 1);
          if (pFirst >= 0) checkOutput("abort_first_vec", int'(firstVec), pFirst);
        end else begin
          checkOutput("reset_vec", int'(vec), 0);
          checkOutput("reset_err_cnt", int'(errCnt), 0);
          checkOutput("reset_first_vec", int'(firstVec), 0);
          checkOutput("reset_first_valid", int'(firstValid), 0);
        end
        repeat (RUNLEN + 2) @(negedge clk);
        checkOutput("kill_still_idle", int'(busy), 0);
        return;
      end
    end
    @(negedge clk);
    checkOutput("idle_busy", int'(busy), 0);
    checkOutput("idle_done", int'(done), 0);
    checkOutput("idle_vec_hold", int'(vec), NV - 1);
    checkOutput("idle_err_hold", int'(errCnt), errs);
  endtask

  // start held high re-launches on the IDLE cycle right after DONE.
  task automatic holdStartTest();
    int t;
    faultMode = 0;
    faultMask = '0;
    @(negedge clk);
    start = 1'b1;
    t = cyc + 1;
    sbq.push_back('{t + RUNLEN, 0, 0, 0, 1});
    sbq.push_back('{t + 2 * RUNLEN + 2, 0, 0, 0, 1});
    for (int i = 0; i < 3 * RUNLEN && cyc < t + 2 * RUNLEN + 4; i++) begin
      @(negedge clk);
      if (cyc >= t + 2 * RUNLEN) start = 1'b0;
    end
    checkOutput("hold_idle_busy", int'(busy), 0);
  endtask

  // Longer settle and a 1-bit counter: three mismatches saturate at 1.
  task automatic runSettle3();
    @(negedge clk);
    startB = 1'b1;
    for (int k = 1; k <= SB_RUNLEN + 1; k++) begin
      @(negedge clk);
      startB = 1'b0;
      if (k <= SB_RUNLEN) begin
        checkOutput("b_vec_trace", int'(vecB), (k - 1) / (SB_S + 1));
        checkOutput("b_busy_trace", int'(busyB), 1);
      end
      checkOutput("b_done_timing", int'(doneB), (k == SB_RUNLEN + 1) ? 1 : 0);
    end
    checkOutput("b_err_saturated", int'(errCntB), 1);
    checkOutput("b_first_vec", int'(firstVecB), 0);
    checkOutput("b_first_valid", int'(firstValidB), 1);
    checkOutput("b_pass", int'(passB), 0);
  endtask

  initial begin
    int kk;
    rstN      = 1'b0;
    start     = 1'b1;
    abortIn   = 1'b0;
    startB    = 1'b0;
    faultMode = 0;
    faultMask = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_vec", int'(vec), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_pass", int'(pass), 0);
    checkOutput("rst_err_cnt", int'(errCnt), 0);
    checkOutput("rst_first_vec", int'(firstVec), 0);
    checkOutput("rst_first_valid", int'(firstValid), 0);
    start = 1'b0;
    rstN  = 1'b1;
    @(negedge clk);
    checkOutput("rst_no_run", int'(busy), 0);

    applyStimulus(0, '0, 0, 0, 1'b0);
    applyStimulus(1, '0, 0, 0, 1'b0);
    applyStimulus(2, '0, 0, 0, 1'b0);
    applyStimulus(0, '0, 4, 1, 1'b0);
    applyStimulus(0, '0, 0, 0, 1'b0);
    applyStimulus(0, '0, 0, 0, 1'b1);
    applyStimulus(3, 4'b1010, 3, 2, 1'b0);
    applyStimulus(3, 4'b1010, 0, 0, 1'b1);
    holdStartTest();
    runSettle3();

    for (int r = 0; r < 16; r++) begin
      if ($urandom_range(0, 3) == 0) begin
        kk = 2 * $urandom_range(0, NV - 1) + 1;
        applyStimulus(3, NV'($urandom), kk, 1, 1'($urandom_range(0, 1)));
      end else begin
        applyStimulus(3, NV'($urandom), 0, 0, 1'($urandom_range(0, 1)));
      end
    end

    @(negedge clk);
    checkOutput("scoreboard_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
